ace_snoop_buffer: RTL and testbench
===================================

# ace_snoop_buffer

Parametrised snoop-channel front end between the ACE interconnect (AC/CR/CD) and the data cache's snoop port. It queues incoming AC snoop requests and throttles them to the cache under an outstanding-snoop limit. It registers each CR response and streams CD data beats, generating `cd_last_o` internally. It flags protocol violations from the cache side.

## Interface
Parameters:
- `AddrWidth`, 64, snoop address width.
- `DataWidth`, 64, CD beat width.
- `LineWidth`, 128, cache-line bits; `Beats = LineWidth/DataWidth`, required ≥1 and a power of two.
- `FifoDepth`, 4, AC queue entries, power of two ≥2.
- `MaxOutstanding`, 2, snoops issued to cache without CR; range 1..15.

Ports (one clock; reset asynchronous, active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: async active-low reset.
- `ac_valid_i` in 1: interconnect AC valid.
- `ac_ready_o` out 1: AC accept.
- `ac_addr_i` in AddrWidth: snoop address.
- `ac_snoop_i` in 4: acsnoop.
- `ac_prot_i` in 3: acprot.
- `snp_req_valid_o` out 1: request to cache.
- `snp_req_ready_i` in 1: cache accepts request.
- `snp_req_addr_o` out AddrWidth: forwarded address.
- `snp_req_snoop_o` out 4: forwarded acsnoop.
- `snp_req_prot_o` out 3: forwarded acprot.
- `snp_resp_valid_i` in 1: cache CR response valid.
- `snp_resp_ready_o` out 1: CR response accepted.
- `snp_resp_i` in 5: crresp; bit0 DataTransfer, bit1 Error, bit2 PassDirty, bit3 IsShared, bit4 WasUnique.
- `snp_data_valid_i` in 1: cache data beat valid.
- `snp_data_ready_o` out 1: beat accepted.
- `snp_data_i` in DataWidth: beat data.
- `cr_valid_o` out 1: CR valid.
- `cr_ready_i` in 1: CR accept.
- `cr_resp_o` out 5: registered crresp.
- `cd_valid_o` out 1: CD valid.
- `cd_ready_i` in 1: CD accept.
- `cd_data_o` out DataWidth: CD data.
- `cd_last_o` out 1: final beat of line.
- `protocol_err_o` out 1: sticky violation flag.

## Operation
- AC queue: FIFO, no fall-through. `ac_ready_o = !full`. Push on `ac_valid_i && ac_ready_o`.
- Issue: `snp_req_valid_o = !empty && (outstanding < MaxOutstanding)`. The request fields are the FIFO head. Pop on `snp_req_valid_o && snp_req_ready_i`.
- `outstanding` counter: +1 on issue, −1 on `snp_resp` handshake. Both in one cycle means unchanged. The counter never exceeds MaxOutstanding.
- Response FSM:
  - RSP_IDLE:
    - `snp_resp_ready_o = (outstanding != 0) && (!cr_valid_o || cr_ready_i)`.
    - On handshake, load `cr_resp_o` and set `cr_valid_o`.
    - If bit0 is set, go to RSP_DATA with `beat = 0`; otherwise stay in RSP_IDLE.
  - RSP_DATA:
    - Pass-through: `cd_valid_o = snp_data_valid_i`, `snp_data_ready_o = cd_ready_i`, `cd_data_o = snp_data_i`, `cd_last_o = (beat == Beats-1)`.
    - `beat` increments on each CD handshake.
    - On the last-beat handshake, return to RSP_IDLE.
    - `snp_resp_ready_o = 0` in RSP_DATA.
- The CR register clears on `cr_ready_i` unless it is reloaded in the same cycle. CR and CD are independent, so CD may complete before CR is accepted.
- Outside RSP_DATA, `cd_valid_o = 0` and `snp_data_ready_o = 0`.
- `protocol_err_o` sets and never clears until reset, on either condition:
  - `snp_data_valid_i` while in RSP_IDLE.
  - `snp_resp_valid_i` while `outstanding == 0`.

## Timing
- Reset values: `ac_ready_o = 1`; all other outputs 0. Counters 0, FSM RSP_IDLE.
- AC accept to `snp_req_valid_o`: minimum 1 cycle.
- `snp_resp` handshake to `cr_valid_o`: 1 cycle, registered.
- CD path: 0-cycle combinational pass-through.
- Full FIFO with simultaneous push and pop: push is refused because `ac_ready_o` depends only on full.
- Simultaneous response handshake and CR accept: the new value is loaded and `cr_valid_o` stays 1, giving back-to-back CRs at one per cycle when `Beats` are not needed.
- Asynchronous reset mid-line discards any partial CD burst and outstanding state.

## Structure
- Add to the shared ACE package:
  - `snoop_req_t` (addr, snoop, prot) reusing `ariane_axi::addr_t`, `ace_pkg::acsnoop_t`, `ace_pkg::acprot_t`.
  - `snoop_resp_t` = `ace_pkg::crresp_t`.
  - Localparam crresp bit indices.
- Sub-module: `fifo_v3` from common_cells for the AC queue, width `$bits(snoop_req_t)`.
- The FSM, counters and CR register stay in this module.

## Test plan
- Single non-data snoop with all readies high: AC at cycle 0 gives `snp_req_valid_o` at cycle 1. A response `5'b01000` gives `cr_valid_o` with `cr_resp_o = 5'b01000` one cycle later, and no CD.
- DataTransfer with Beats=2: response `5'b00101`, then beats `0xA`, `0xB`. CD emits `0xA` with last=0 and `0xB` with last=1. `cd_ready_i` stalled 3 cycles mid-burst holds the beat.
- Throttle with MaxOutstanding=2: 4 ACs queued and cache never responds. Exactly 2 issued, `snp_req_valid_o` drops. After one response, a third issues the next cycle.
- FIFO full with FifoDepth=4 and `snp_req_ready_i=0`: after 4 ACs, `ac_ready_o = 0`. A fifth AC is held and is accepted after one pop.
- CR backpressure: `cr_ready_i = 0` blocks a second response (`snp_resp_ready_o = 0`). Releasing it loads the second CR in the same cycle.
- Violations: data beat in RSP_IDLE or response with `outstanding == 0` sets `protocol_err_o`. It stays set until `rst_ni` is asserted mid-burst, after which all outputs return to reset values.

Source files
------------

// File: rtl/ace_snoop_buffer_pkg.sv
// Shared types for the ACE snoop-channel front end: AC request attributes,
// CR response encoding and the response FSM states.
package ace_snoop_buffer_pkg;

    typedef logic [3:0] acsnoop_t;
    typedef logic [2:0] acprot_t;
    typedef logic [4:0] crresp_t;

    // The address width is a module parameter, so only the fixed-width
    // attributes travel as a struct; the address is packed alongside it.
    typedef struct packed {
        acsnoop_t snoop;
        acprot_t  prot;
    } snoop_attr_t;

    typedef crresp_t snoop_resp_t;

    localparam int unsigned CrDataTransfer = 0;
    localparam int unsigned CrError        = 1;
    localparam int unsigned CrPassDirty    = 2;
    localparam int unsigned CrIsShared     = 3;
    localparam int unsigned CrWasUnique    = 4;

    // Wide enough for the largest supported outstanding limit (15).
    localparam int unsigned OutstandingWidth = 4;

    typedef enum logic [0:0] {
        RSP_IDLE = 1'b0,
        RSP_DATA = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/ace_snoop_buffer_fifo.sv
// Synchronous FIFO without fall-through; the head entry is visible on data_o
// whenever the queue is not empty.
module ace_snoop_buffer_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr_reg;
    logic [PtrWidth-1:0] rd_ptr_reg;
    logic [PtrWidth:0]   count_reg;
    logic [PtrWidth:0]   count_next;
    logic                push_ok;
    logic                pop_ok;

    assign full_o  = (count_reg == (PtrWidth+1)'(Depth));
    assign empty_o = (count_reg == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + (PtrWidth+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count_reg - (PtrWidth+1)'(1);
        end
    end

    // Storage carries no reset so it can map onto plain RAM cells.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PtrWidth'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PtrWidth'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/ace_snoop_buffer.sv
// ACE snoop front end: queues AC requests, throttles issue to the cache,
// registers CR responses, streams CD beats and flags cache-side violations.
module ace_snoop_buffer
    import ace_snoop_buffer_pkg::*;
#(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned LineWidth      = 128,
    parameter int unsigned FifoDepth      = 4,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    input  logic [2:0]           ac_prot_i,
    output logic                 snp_req_valid_o,
    input  logic                 snp_req_ready_i,
    output logic [AddrWidth-1:0] snp_req_addr_o,
    output logic [3:0]           snp_req_snoop_o,
    output logic [2:0]           snp_req_prot_o,
    input  logic                 snp_resp_valid_i,
    output logic                 snp_resp_ready_o,
    input  logic [4:0]           snp_resp_i,
    input  logic                 snp_data_valid_i,
    output logic                 snp_data_ready_o,
    input  logic [DataWidth-1:0] snp_data_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 protocol_err_o
);

    localparam int unsigned Beats     = LineWidth / DataWidth;
    localparam int unsigned BeatWidth = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned AttrWidth = $bits(snoop_attr_t);
    localparam int unsigned ReqWidth  = AddrWidth + AttrWidth;

    localparam logic [BeatWidth-1:0]        LastBeat = BeatWidth'(Beats - 1);
    localparam logic [OutstandingWidth-1:0] MaxOut   = OutstandingWidth'(MaxOutstanding);

    snoop_attr_t                 ac_attr;
    snoop_attr_t                 head_attr;
    logic [ReqWidth-1:0]         fifo_wdata;
    logic [ReqWidth-1:0]         fifo_rdata;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        ac_push;
    logic                        issue;
    logic                        resp_hs;
    logic                        cd_hs;
    logic                        rsp_idle;
    logic                        violation;

    rsp_state_t                  state_reg;
    logic [BeatWidth-1:0]        beat_reg;
    logic [OutstandingWidth-1:0] outstanding_reg;
    logic [OutstandingWidth-1:0] outstanding_next;
    logic                        cr_valid_reg;
    snoop_resp_t                 cr_resp_reg;
    logic                        err_reg;

    // AC queue
    assign ac_attr    = '{snoop: ac_snoop_i, prot: ac_prot_i};
    assign fifo_wdata = {ac_addr_i, ac_attr};
    assign ac_ready_o = !fifo_full;
    assign ac_push    = ac_valid_i && ac_ready_o;

    ace_snoop_buffer_fifo #(
        .Width (ReqWidth),
        .Depth (FifoDepth)
    ) u_ac_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ac_push),
        .data_i  (fifo_wdata),
        .pop_i   (issue),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Request fields are forced to zero while idle so stale or uninitialised
    // queue storage never shows on the cache port.
    assign head_attr       = snoop_attr_t'(fifo_rdata[AttrWidth-1:0]);
    assign snp_req_valid_o = !fifo_empty && (outstanding_reg < MaxOut);
    assign snp_req_addr_o  = snp_req_valid_o ? fifo_rdata[ReqWidth-1 -: AddrWidth] : '0;
    assign snp_req_snoop_o = snp_req_valid_o ? head_attr.snoop : '0;
    assign snp_req_prot_o  = snp_req_valid_o ? head_attr.prot : '0;
    assign issue           = snp_req_valid_o && snp_req_ready_i;

    // Response side
    assign rsp_idle         = (state_reg == RSP_IDLE);
    assign snp_resp_ready_o = rsp_idle && (outstanding_reg != '0) && (!cr_valid_reg || cr_ready_i);
    assign resp_hs          = snp_resp_valid_i && snp_resp_ready_o;

    assign cd_valid_o       = !rsp_idle && snp_data_valid_i;
    assign snp_data_ready_o = !rsp_idle && cd_ready_i;
    assign cd_data_o        = rsp_idle ? '0 : snp_data_i;
    assign cd_last_o        = !rsp_idle && (beat_reg == LastBeat);
    assign cd_hs            = cd_valid_o && cd_ready_i;

    assign cr_valid_o     = cr_valid_reg;
    assign cr_resp_o      = cr_resp_reg;
    assign protocol_err_o = err_reg;

    assign violation = (rsp_idle && snp_data_valid_i)
                    || (snp_resp_valid_i && (outstanding_reg == '0));

    always_comb begin
        outstanding_next = outstanding_reg;
        if (issue && !resp_hs) begin
            outstanding_next = outstanding_reg + OutstandingWidth'(1);
        end else if (!issue && resp_hs) begin
            outstanding_next = outstanding_reg - OutstandingWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_reg <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= RSP_IDLE;
            beat_reg     <= '0;
            cr_valid_reg <= 1'b0;
            cr_resp_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            unique case (state_reg)
                RSP_IDLE: begin
                    if (resp_hs && snp_resp_i[CrDataTransfer]) begin
                        state_reg <= RSP_DATA;
                        beat_reg  <= '0;
                    end
                end
                RSP_DATA: begin
                    if (cd_hs) begin
                        beat_reg <= beat_reg + BeatWidth'(1);
                        if (beat_reg == LastBeat) begin
                            state_reg <= RSP_IDLE;
                        end
                    end
                end
                default: state_reg <= RSP_IDLE;
            endcase

            // A reload in the same cycle as an accept keeps CR valid for
            // back-to-back responses.
            if (resp_hs) begin
                cr_valid_reg <= 1'b1;
                cr_resp_reg  <= snp_resp_i;
            end else if (cr_ready_i) begin
                cr_valid_reg <= 1'b0;
                cr_resp_reg  <= '0;
            end

            if (violation) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ace_snoop_buffer.sv
// Scenario bench for ace_snoop_buffer: AC requests are pushed to a scoreboard
// on acceptance and popped when the buffer issues them to the cache.
module tb_ace_snoop_buffer;

    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned ReqBits   = AddrWidth + 7;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 ac_valid_i;
    logic                 ac_ready_o;
    logic [AddrWidth-1:0] ac_addr_i;
    logic [3:0]           ac_snoop_i;
    logic [2:0]           ac_prot_i;
    logic                 snp_req_valid_o;
    logic                 snp_req_ready_i;
    logic [AddrWidth-1:0] snp_req_addr_o;
    logic [3:0]           snp_req_snoop_o;
    logic [2:0]           snp_req_prot_o;
    logic                 snp_resp_valid_i;
    logic                 snp_resp_ready_o;
    logic [4:0]           snp_resp_i;
    logic                 snp_data_valid_i;
    logic                 snp_data_ready_o;
    logic [DataWidth-1:0] snp_data_i;
    logic                 cr_valid_o;
    logic                 cr_ready_i;
    logic [4:0]           cr_resp_o;
    logic                 cd_valid_o;
    logic                 cd_ready_i;
    logic [DataWidth-1:0] cd_data_o;
    logic                 cd_last_o;
    logic                 protocol_err_o;

    int checks   = 0;
    int failures = 0;
    int issued_cnt = 0;

    logic [ReqBits-1:0]   req_q [$];
    logic [4:0]           cr_q  [$];
    logic [DataWidth:0]   cd_q  [$];
    logic [ReqBits-1:0]   exp_req;

    ace_snoop_buffer #(
        .AddrWidth      (64),
        .DataWidth      (64),
        .LineWidth      (128),
        .FifoDepth      (4),
        .MaxOutstanding (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ac_valid_i       (ac_valid_i),
        .ac_ready_o       (ac_ready_o),
        .ac_addr_i        (ac_addr_i),
        .ac_snoop_i       (ac_snoop_i),
        .ac_prot_i        (ac_prot_i),
        .snp_req_valid_o  (snp_req_valid_o),
        .snp_req_ready_i  (snp_req_ready_i),
        .snp_req_addr_o   (snp_req_addr_o),
        .snp_req_snoop_o  (snp_req_snoop_o),
        .snp_req_prot_o   (snp_req_prot_o),
        .snp_resp_valid_i (snp_resp_valid_i),
        .snp_resp_ready_o (snp_resp_ready_o),
        .snp_resp_i       (snp_resp_i),
        .snp_data_valid_i (snp_data_valid_i),
        .snp_data_ready_o (snp_data_ready_o),
        .snp_data_i       (snp_data_i),
        .cr_valid_o       (cr_valid_o),
        .cr_ready_i       (cr_ready_i),
        .cr_resp_o        (cr_resp_o),
        .cd_valid_o       (cd_valid_o),
        .cd_ready_i       (cd_ready_i),
        .cd_data_o        (cd_data_o),
        .cd_last_o        (cd_last_o),
        .protocol_err_o   (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Issue monitor: inputs are stable between negedge and the next posedge,
    // so valid && ready here is the handshake about to happen.
    always @(negedge clk_i) begin
        if (rst_ni && snp_req_valid_o && snp_req_ready_i) begin
            checks++;
            issued_cnt++;
            if (req_q.size() == 0) begin
                failures++;
                $display("FAIL req_issue unexpected request addr=%0h", snp_req_addr_o);
            end else begin
                exp_req = req_q.pop_front();
                if ({snp_req_addr_o, snp_req_snoop_o, snp_req_prot_o} !== exp_req) begin
                    failures++;
                    $display("FAIL req_fields got=%0h exp=%0h",
                             {snp_req_addr_o, snp_req_snoop_o, snp_req_prot_o}, exp_req);
                end else begin
                    $display("req issued addr=%0h snoop=%0h prot=%0h",
                             snp_req_addr_o, snp_req_snoop_o, snp_req_prot_o);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ac_send(input logic [AddrWidth-1:0] addr, input logic [3:0] snp,
                           input logic [2:0] prot);
        bit done;
        done       = 1'b0;
        ac_valid_i = 1'b1;
        ac_addr_i  = addr;
        ac_snoop_i = snp;
        ac_prot_i  = prot;
        for (int i = 0; i < 40 && !done; i++) begin
            if (ac_ready_o) begin
                @(posedge clk_i);
                req_q.push_back({addr, snp, prot});
                done = 1'b1;
                #1;
            end else begin
                step();
            end
        end
        ac_valid_i = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL ac_accept timeout got=ready_low exp=accepted addr=%0h", addr);
        end else begin
            $display("ac accepted addr=%0h", addr);
        end
    endtask

    // Response is only presented once the buffer is ready, so it never trips
    // the zero-outstanding violation.
    task automatic respond(input logic [4:0] resp);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (snp_resp_ready_o) begin
                snp_resp_valid_i = 1'b1;
                snp_resp_i       = resp;
                @(posedge clk_i);
                cr_q.push_back(resp);
                done = 1'b1;
                #1;
            end else begin
                step();
            end
        end
        snp_resp_valid_i = 1'b0;
        snp_resp_i       = '0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL resp_accept timeout got=ready_low exp=accepted resp=%b", resp);
        end else begin
            checks++;
            if (cr_valid_o !== 1'b1 || cr_resp_o !== cr_q[0]) begin
                failures++;
                $display("FAIL cr_out got=%b/%b exp=1/%b", cr_valid_o, cr_resp_o, cr_q[0]);
            end else begin
                $display("cr out resp=%b", cr_resp_o);
            end
            void'(cr_q.pop_front());
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        ac_valid_i = 0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
        snp_req_ready_i = 0; snp_resp_valid_i = 0; snp_resp_i = '0;
        snp_data_valid_i = 0; snp_data_i = '0; cr_ready_i = 1; cd_ready_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({ac_ready_o, snp_req_valid_o, snp_resp_ready_o, snp_data_ready_o,
             cr_valid_o, cd_valid_o, cd_last_o, protocol_err_o} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=10000000", {ac_ready_o, snp_req_valid_o,
                     snp_resp_ready_o, snp_data_ready_o, cr_valid_o, cd_valid_o, cd_last_o,
                     protocol_err_o});
        end
        checks++;
        if (cr_resp_o !== 5'd0 || cd_data_o !== '0 || snp_req_addr_o !== '0) begin
            failures++;
            $display("FAIL reset_data got=%b/%0h/%0h exp=0/0/0", cr_resp_o, cd_data_o, snp_req_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        checks++;
        if (ac_ready_o !== 1'b1 || snp_req_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got=%b%b exp=10", ac_ready_o, snp_req_valid_o);
        end
        $display("reset done");
    endtask

    task automatic test_single();
        snp_req_ready_i = 1'b1;
        ac_send(64'h1000, 4'h1, 3'h2);
        checks++;
        if (snp_req_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL single_req_latency got=%b exp=1", snp_req_valid_o);
        end
        step();
        snp_req_ready_i = 1'b0;
        checks++;
        if (snp_req_valid_o !== 1'b0 || cr_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL single_after_issue got=%b%b exp=00", snp_req_valid_o, cr_valid_o);
        end
        respond(5'b01000);
        checks++;
        if (cd_valid_o !== 1'b0 || snp_data_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL single_no_cd got=%b%b exp=00", cd_valid_o, snp_data_ready_o);
        end
        step();
        checks++;
        if (cr_valid_o !== 1'b0 || protocol_err_o !== 1'b0) begin
            failures++;
            $display("FAIL single_cr_clear got=%b%b exp=00", cr_valid_o, protocol_err_o);
        end
    endtask

    task automatic test_data_transfer();
        snp_req_ready_i = 1'b1;
        ac_send(64'h2040, 4'h7, 3'h0);
        ac_send(64'h2080, 4'h9, 3'h1);
        step();
        snp_req_ready_i = 1'b0;
        respond(5'b00101);
        checks++;
        if (snp_resp_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL data_resp_blocked got=%b exp=0", snp_resp_ready_o);
        end
        cd_q.push_back({1'b0, 64'hA});
        snp_data_valid_i = 1'b1;
        snp_data_i = 64'hA;
        cd_ready_i = 1'b1;
        #1;
        checks++;
        if (cd_valid_o !== 1'b1 || {cd_last_o, cd_data_o} !== cd_q[0]) begin
            failures++;
            $display("FAIL cd_beat0 got=%b/%b/%0h exp=1/%0h", cd_valid_o, cd_last_o, cd_data_o, cd_q[0]);
        end else begin
            $display("cd beat data=%0h last=%b", cd_data_o, cd_last_o);
        end
        @(posedge clk_i);
        void'(cd_q.pop_front());
        #1;
        cd_q.push_back({1'b1, 64'hB});
        snp_data_i = 64'hB;
        cd_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (cd_valid_o !== 1'b1 || snp_data_ready_o !== 1'b0 || {cd_last_o, cd_data_o} !== cd_q[0]) begin
                failures++;
                $display("FAIL cd_stall got=%b%b/%b/%0h exp=10/%0h", cd_valid_o, snp_data_ready_o,
                         cd_last_o, cd_data_o, cd_q[0]);
            end
            @(posedge clk_i);
            #1;
        end
        cd_ready_i = 1'b1;
        #1;
        checks++;
        if (snp_data_ready_o !== 1'b1 || {cd_last_o, cd_data_o} !== cd_q[0]) begin
            failures++;
            $display("FAIL cd_beat1 got=%b/%b/%0h exp=1/%0h", snp_data_ready_o, cd_last_o, cd_data_o, cd_q[0]);
        end else begin
            $display("cd beat data=%0h last=%b", cd_data_o, cd_last_o);
        end
        @(posedge clk_i);
        void'(cd_q.pop_front());
        #1;
        snp_data_valid_i = 1'b0;
        #1;
        checks++;
        if (cd_valid_o !== 1'b0 || snp_data_ready_o !== 1'b0 || snp_resp_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL cd_done got=%b%b%b exp=001", cd_valid_o, snp_data_ready_o, snp_resp_ready_o);
        end
        respond(5'b00000);
        step();
        checks++;
        if (protocol_err_o !== 1'b0 || snp_resp_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL data_end got=%b%b exp=00", protocol_err_o, snp_resp_ready_o);
        end
    endtask

    task automatic test_throttle();
        int base;
        base = issued_cnt;
        snp_req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ac_send(64'h3000 + 64'(i * 64), 4'(i + 2), 3'(i));
        end
        repeat (4) step();
        checks++;
        if (issued_cnt - base !== 2 || snp_req_valid_o !== 1'b0 || ac_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL throttle_limit got=%0d/%b/%b exp=2/0/1", issued_cnt - base,
                     snp_req_valid_o, ac_ready_o);
        end
        respond(5'b00000);
        checks++;
        if (snp_req_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL throttle_release got=%b exp=1", snp_req_valid_o);
        end
        repeat (3) respond(5'b00000);
        repeat (2) step();
        checks++;
        if (issued_cnt - base !== 4 || snp_req_valid_o !== 1'b0 || snp_resp_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL throttle_drain got=%0d/%b/%b exp=4/0/0", issued_cnt - base,
                     snp_req_valid_o, snp_resp_ready_o);
        end
        snp_req_ready_i = 1'b0;
    endtask

    task automatic test_fifo_full();
        int base;
        base = issued_cnt;
        snp_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ac_send(64'h4000 + 64'(i * 64), 4'hA, 3'(i));
        end
        checks++;
        if (ac_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full got=%b exp=0", ac_ready_o);
        end
        fork
            ac_send(64'h4F00, 4'hB, 3'h7);
            begin
                step();
                checks++;
                if (ac_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL fifo_hold got=%b exp=0", ac_ready_o);
                end
                snp_req_ready_i = 1'b1;
                @(posedge clk_i);
                #1;
                snp_req_ready_i = 1'b0;
                checks++;
                if (issued_cnt - base !== 1) begin
                    failures++;
                    $display("FAIL fifo_one_pop got=%0d exp=1", issued_cnt - base);
                end
            end
        join
        snp_req_ready_i = 1'b1;
        repeat (5) respond(5'b00000);
        step();
        checks++;
        if (issued_cnt - base !== 5 || snp_resp_ready_o !== 1'b0 || ac_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL fifo_drain got=%0d/%b/%b exp=5/0/1", issued_cnt - base,
                     snp_resp_ready_o, ac_ready_o);
        end
        snp_req_ready_i = 1'b0;
    endtask

    task automatic test_cr_backpressure();
        cr_ready_i = 1'b0;
        snp_req_ready_i = 1'b1;
        ac_send(64'h5000, 4'h1, 3'h0);
        ac_send(64'h5040, 4'h2, 3'h0);
        repeat (2) step();
        snp_req_ready_i = 1'b0;
        respond(5'b01000);
        snp_resp_valid_i = 1'b1;
        snp_resp_i = 5'b10000;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (snp_resp_ready_o !== 1'b0 || cr_valid_o !== 1'b1 || cr_resp_o !== 5'b01000) begin
                failures++;
                $display("FAIL cr_block got=%b/%b/%b exp=0/1/01000", snp_resp_ready_o, cr_valid_o, cr_resp_o);
            end
            @(posedge clk_i);
            #1;
        end
        cr_ready_i = 1'b1;
        #1;
        checks++;
        if (snp_resp_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL cr_release_ready got=%b exp=1", snp_resp_ready_o);
        end
        @(posedge clk_i);
        #1;
        snp_resp_valid_i = 1'b0;
        snp_resp_i = '0;
        checks++;
        if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b10000) begin
            failures++;
            $display("FAIL cr_reload got=%b/%b exp=1/10000", cr_valid_o, cr_resp_o);
        end else begin
            $display("cr out resp=%b", cr_resp_o);
        end
        step();
        checks++;
        if (cr_valid_o !== 1'b0 || snp_resp_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL cr_bp_end got=%b%b exp=00", cr_valid_o, snp_resp_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        snp_req_ready_i = 1'b1;
        ac_send(64'h6000, 4'h3, 3'h1);
        ac_send(64'h6040, 4'h4, 3'h2);
        repeat (2) step();
        snp_req_ready_i = 1'b0;
        snp_resp_valid_i = 1'b1;
        snp_resp_i = 5'b00010;
        @(posedge clk_i);
        #1;
        snp_resp_i = 5'b11000;
        checks++;
        if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b00010) begin
            failures++;
            $display("FAIL b2b_first got=%b/%b exp=1/00010", cr_valid_o, cr_resp_o);
        end
        @(posedge clk_i);
        #1;
        snp_resp_valid_i = 1'b0;
        snp_resp_i = '0;
        checks++;
        if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b11000) begin
            failures++;
            $display("FAIL b2b_second got=%b/%b exp=1/11000", cr_valid_o, cr_resp_o);
        end
        step();
        checks++;
        if (cr_valid_o !== 1'b0 || snp_resp_ready_o !== 1'b0 || protocol_err_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got=%b%b%b exp=000", cr_valid_o, snp_resp_ready_o, protocol_err_o);
        end
    endtask

    task automatic test_violations();
        snp_data_valid_i = 1'b1;
        #1;
        checks++;
        if (cd_valid_o !== 1'b0 || snp_data_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_data_blocked got=%b%b exp=00", cd_valid_o, snp_data_ready_o);
        end
        @(posedge clk_i);
        #1;
        snp_data_valid_i = 1'b0;
        step();
        checks++;
        if (protocol_err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_idle_data got=%b exp=1", protocol_err_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (protocol_err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_reset got=%b exp=0", protocol_err_o);
        end
        step();
        rst_ni = 1'b1;
        step();
        snp_resp_valid_i = 1'b1;
        step();
        snp_resp_valid_i = 1'b0;
        checks++;
        if (protocol_err_o !== 1'b1 || cr_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL err_zero_outstanding got=%b%b exp=10", protocol_err_o, cr_valid_o);
        end
        snp_req_ready_i = 1'b1;
        ac_send(64'h7000, 4'h5, 3'h3);
        step();
        snp_req_ready_i = 1'b0;
        respond(5'b00001);
        snp_data_valid_i = 1'b1;
        snp_data_i = 64'h55;
        cd_ready_i = 1'b1;
        #1;
        checks++;
        if (cd_valid_o !== 1'b1 || cd_last_o !== 1'b0) begin
            failures++;
            $display("FAIL burst_start got=%b%b exp=10", cd_valid_o, cd_last_o);
        end
        @(posedge clk_i);
        #2;
        snp_data_valid_i = 1'b0;
        rst_ni = 1'b0;
        req_q.delete();
        cr_q.delete();
        cd_q.delete();
        #1;
        checks++;
        if ({ac_ready_o, snp_req_valid_o, snp_resp_ready_o, snp_data_ready_o,
             cr_valid_o, cd_valid_o, cd_last_o, protocol_err_o} !== 8'b1000_0000 ||
            cr_resp_o !== 5'd0 || cd_data_o !== '0) begin
            failures++;
            $display("FAIL midburst_reset got=%b/%b/%0h exp=10000000/0/0", {ac_ready_o,
                     snp_req_valid_o, snp_resp_ready_o, snp_data_ready_o, cr_valid_o,
                     cd_valid_o, cd_last_o, protocol_err_o}, cr_resp_o, cd_data_o);
        end else begin
            $display("mid-burst reset outputs cleared");
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        checks++;
        if (ac_ready_o !== 1'b1 || cd_valid_o !== 1'b0 || snp_data_ready_o !== 1'b0 || protocol_err_o !== 1'b0) begin
            failures++;
            $display("FAIL after_reset got=%b%b%b%b exp=1000", ac_ready_o, cd_valid_o,
                     snp_data_ready_o, protocol_err_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_data_transfer();
        test_throttle();
        test_fifo_full();
        test_cr_backpressure();
        test_back_to_back();
        test_violations();
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
